// File: rtl/pio_result_display.sv
// pio_result_display: debounces the CPU result byte from the PIO port and shows the
// accepted value on a 3-digit, time-multiplexed, active-low 7-segment display.
// Default build shows the value as two hex digits with the top digit blank.
// Define PIO_RESULT_DISPLAY_BCD_EN to show it as three decimal digits instead. In that
// build a sequential double-dabble converter produces the decimal digits.
module pio_result_display #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REFRESH_DIV   = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_in,
  output logic [7:0] shown_value,
  output logic       update,
  output logic [2:0] dig_n,
  output logic [6:0] seg_n
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] StableMax = SW'(STABLE_CYCLES);
  localparam logic [DW-1:0] DivMax    = DW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SegBlank  = 7'h7F;

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [7:0]    prev_q, prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    shown_q, shown_d;
  logic          update_q, update_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    dig_q, dig_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic [1:0]    idx_next;
  logic [3:0]    d0, d1, d2;
  logic          blank2;

  // Stability filter: accept a value once it has been unchanged for STABLE_CYCLES cycles
  always_comb begin
    prev_d   = prev_q;
    stab_d   = stab_q;
    shown_d  = shown_q;
    update_d = 1'b0;
    if (pio_in != prev_q) begin
      prev_d = pio_in;
      stab_d = '0;
    end else if (stab_q < StableMax) begin
      stab_d = stab_q + 1'b1;
      // Re-stabilising on the value already shown is not an update
      if (stab_d == StableMax && prev_q != shown_q) begin
        shown_d  = prev_q;
        update_d = 1'b1;
      end
    end
  end

`ifdef PIO_RESULT_DISPLAY_BCD_EN
  typedef enum logic [1:0] {StIdle, StShift, StLoad} bcd_state_e;

  bcd_state_e state_q, state_d;
  logic [19:0] sr_q, sr_d, sr_adj;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;

  // Double-dabble: {hundreds, tens, ones, binary} shifted left once per cycle.
  // An acceptance restarts the conversion from the value being accepted.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    sr_adj  = sr_q;
    if (update_d) begin
      sr_d    = {12'd0, prev_q};
      iter_d  = 3'd0;
      state_d = StShift;
    end else begin
      unique case (state_q)
        StShift: begin
          if (sr_q[11:8] >= 4'd5)  sr_adj[11:8]  = sr_q[11:8] + 4'd3;
          if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
          if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
          sr_d   = {sr_adj[18:0], 1'b0};
          iter_d = iter_q + 3'd1;
          if (iter_q == 3'd7) state_d = StLoad;
        end
        StLoad: begin
          hund_d  = sr_q[19:16];
          tens_d  = sr_q[15:12];
          ones_d  = sr_q[11:8];
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Converter state and displayed BCD digits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      iter_q  <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  // Decimal digits, all lit
  always_comb begin
    d0     = ones_q;
    d1     = tens_q;
    d2     = hund_q;
    blank2 = 1'b0;
  end
`else
  // Hex digits, top digit dark
  always_comb begin
    d0     = shown_q[3:0];
    d1     = shown_q[7:4];
    d2     = 4'd0;
    blank2 = 1'b1;
  end
`endif

  // Scan: on each divider wrap, select the next digit and register its segments
  always_comb begin
    tick     = (div_q == DivMax);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_next = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    idx_d    = idx_q;
    dig_d    = dig_q;
    seg_d    = seg_q;
    if (tick) begin
      idx_d = idx_next;
      dig_d = ~(3'b001 << idx_next);
      unique case (idx_next)
        2'd0:    seg_d = hex_seg(d0);
        2'd1:    seg_d = hex_seg(d1);
        default: seg_d = blank2 ? SegBlank : hex_seg(d2);
      endcase
    end
  end

  // Filter and scan state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= 8'd0;
      stab_q   <= StableMax;
      shown_q  <= 8'd0;
      update_q <= 1'b0;
      div_q    <= '0;
      idx_q    <= 2'd0;
      dig_q    <= 3'b111;
      seg_q    <= SegBlank;
    end else begin
      prev_q   <= prev_d;
      stab_q   <= stab_d;
      shown_q  <= shown_d;
      update_q <= update_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
    end
  end

  assign shown_value = shown_q;
  assign update      = update_q;
  assign dig_n       = dig_q;
  assign seg_n       = seg_q;

endmodule

// File: tb/tb_pio_result_display.sv
// Directed bench for pio_result_display with STABLE_CYCLES=4, REFRESH_DIV=4.
// Expected display values follow PIO_RESULT_DISPLAY_BCD_EN when it is defined.
module tb_pio_result_display;

  logic       clk;
  logic       reset_n;
  logic [7:0] pio_in;
  logic [7:0] shown_value;
  logic       update;
  logic [2:0] dig_n;
  logic [6:0] seg_n;

  int checks = 0;
  int errors = 0;

`ifdef PIO_RESULT_DISPLAY_BCD_EN
  localparam logic [6:0] Exp3aD0 = 7'h00;  // 58 decimal: ones 8
  localparam logic [6:0] Exp3aD1 = 7'h12;  // tens 5
  localparam logic [6:0] Exp3aD2 = 7'h40;  // hundreds 0
  localparam logic [6:0] ExpZeroD2 = 7'h40;
`else
  localparam logic [6:0] Exp3aD0 = 7'h08;
  localparam logic [6:0] Exp3aD1 = 7'h30;
  localparam logic [6:0] Exp3aD2 = 7'h7F;
  localparam logic [6:0] ExpZeroD2 = 7'h7F;
`endif

  pio_result_display #(
    .STABLE_CYCLES(4),
    .REFRESH_DIV  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pio_in     (pio_in),
    .shown_value(shown_value),
    .update     (update),
    .dig_n      (dig_n),
    .seg_n      (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the given digit is selected, then check its segments
  task automatic see_digit(input int idx, input logic [6:0] exp, input string tag);
    logic [2:0] want;
    int n;
    want = ~(3'b001 << idx);
    n = 0;
    while (dig_n !== want && n < 16) begin
      step();
      n++;
    end
    check({tag, "_dig"}, {13'd0, dig_n}, {13'd0, want});
    check({tag, "_seg"}, {9'd0, seg_n}, {9'd0, exp});
  endtask

  // Step until update is seen (bounded), leaving time just after that edge
  task automatic wait_update(input string tag);
    int n;
    n = 0;
    step();
    while (update !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check(tag, {15'd0, update}, 16'd1);
  endtask

  initial begin
    int pulses;
    logic [7:0] last;
    reset_n = 1'b0;
    pio_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_shown", {8'd0, shown_value}, 16'h0000);
    check("rst_update", {15'd0, update}, 16'd0);
    check("rst_dig", {13'd0, dig_n}, 16'h0007);
    check("rst_seg", {9'd0, seg_n}, 16'h007F);

    // Scan bring-up: dark for 3 cycles, then 1, 2, 0
    reset_n = 1'b1;
    repeat (3) step();
    check("pre_tick_dig", {13'd0, dig_n}, 16'h0007);
    check("pre_tick_seg", {9'd0, seg_n}, 16'h007F);
    step();
    check("tick1_dig", {13'd0, dig_n}, 16'h0005);
    check("tick1_seg", {9'd0, seg_n}, 16'h0040);
    repeat (4) step();
    check("tick2_dig", {13'd0, dig_n}, 16'h0003);
    check("tick2_seg", {9'd0, seg_n}, {9'd0, ExpZeroD2});
    repeat (4) step();
    check("tick3_dig", {13'd0, dig_n}, 16'h0006);
    check("tick3_seg", {9'd0, seg_n}, 16'h0040);

    // Accept 0x3A: captured at the first edge, shown 4 edges later
    pio_in = 8'h3A;
    repeat (4) step();
    check("3a_early_shown", {8'd0, shown_value}, 16'h0000);
    check("3a_early_upd", {15'd0, update}, 16'd0);
    step();
    check("3a_shown", {8'd0, shown_value}, 16'h003A);
    check("3a_upd", {15'd0, update}, 16'd1);
    step();
    check("3a_upd_drop", {15'd0, update}, 16'd0);
    repeat (16) step();
    see_digit(0, Exp3aD0, "3a_d0");
    see_digit(1, Exp3aD1, "3a_d1");
    see_digit(2, Exp3aD2, "3a_d2");

    // Glitch of 3 cycles is rejected
    pio_in = 8'h55;
    repeat (3) step();
    pio_in = 8'h3A;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (update === 1'b1) pulses++;
    end
    check("glitch_pulses", pulses[15:0], 16'd0);
    check("glitch_shown", {8'd0, shown_value}, 16'h003A);

    // Ping-pong 0x55 then back to 0x3A
    pulses = 0;
    last = 8'h00;
    pio_in = 8'h55;
    for (int i = 0; i < 7; i++) begin
      step();
      if (update === 1'b1) begin
        pulses++;
        last = shown_value;
      end
    end
    check("pp1_pulses", pulses[15:0], 16'd1);
    check("pp1_value", {8'd0, last}, 16'h0055);
    pio_in = 8'h3A;
    for (int i = 0; i < 14; i++) begin
      step();
      if (update === 1'b1) begin
        pulses++;
        last = shown_value;
      end
    end
    check("pp2_pulses", pulses[15:0], 16'd2);
    check("pp2_value", {8'd0, last}, 16'h003A);

    // Asynchronous reset mid-filter and mid-scan
    pio_in = 8'h81;
    repeat (3) step();
    check("pre_rst_shown", {8'd0, shown_value}, 16'h003A);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_shown", {8'd0, shown_value}, 16'h0000);
    check("arst_update", {15'd0, update}, 16'd0);
    check("arst_dig", {13'd0, dig_n}, 16'h0007);
    check("arst_seg", {9'd0, seg_n}, 16'h007F);
    pio_in = 8'h00;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (update === 1'b1) pulses++;
    end
    check("post_rst_dig", {13'd0, dig_n}, 16'h0007);
    step();
    check("post_rst_tick", {13'd0, dig_n}, 16'h0005);
    check("post_rst_pulses", pulses[15:0], 16'd0);
    check("post_rst_shown", {8'd0, shown_value}, 16'h0000);

`ifdef PIO_RESULT_DISPLAY_BCD_EN
    // 0xFF = 255
    pio_in = 8'hFF;
    wait_update("bcd_ff_upd");
    repeat (24) step();
    see_digit(0, 7'h12, "bcd_ff_d0");
    see_digit(1, 7'h12, "bcd_ff_d1");
    see_digit(2, 7'h24, "bcd_ff_d2");
    // 0xFF conversion interrupted by 0x07
    pio_in = 8'h3A;
    wait_update("bcd_3a_upd");
    pio_in = 8'hFF;
    wait_update("bcd_ff2_upd");
    pio_in = 8'h07;
    wait_update("bcd_07_upd");
    check("bcd_07_shown", {8'd0, shown_value}, 16'h0007);
    repeat (24) step();
    see_digit(0, 7'h78, "bcd_07_d0");
    see_digit(1, 7'h40, "bcd_07_d1");
    see_digit(2, 7'h40, "bcd_07_d2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
